// File: rtl/pipeline_stage_chain.sv
// pipeline_stage_chain: parametrised chain of pipeline stage registers.
// Each stage carries valid, payload, destination register number and
// write-enable. Supports per-stage stall with bubble insertion, flush of
// younger stages, load-use hazard detection at entry and a valid-entry count.
// Stage 0 is the youngest; stage STAGES-1 is the oldest and drives out*.
module pipeline_stage_chain #(
   parameter int DATA_WIDTH    = 32,
   parameter int STAGES        = 4,
   parameter int REG_NUM_WIDTH = 5
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             inValid,
   input  logic [DATA_WIDTH-1:0]            inData,
   input  logic [REG_NUM_WIDTH-1:0]         inWrNum,
   input  logic                             inWrEnable,
   input  logic                             inIsLoad,
   input  logic [REG_NUM_WIDTH-1:0]         inRdNumA,
   input  logic [REG_NUM_WIDTH-1:0]         inRdNumB,
   input  logic                             inRdUseA,
   input  logic                             inRdUseB,
   output logic                             inReady,
   input  logic [STAGES-1:0]                stageStall,
   input  logic                             flushValid,
   input  logic [$clog2(STAGES+1)-1:0]      flushStage,
   output logic [STAGES-1:0]                stageValid,
   output logic [STAGES*DATA_WIDTH-1:0]     stageData,
   output logic                             outValid,
   output logic [DATA_WIDTH-1:0]            outData,
   output logic [REG_NUM_WIDTH-1:0]         outWrNum,
   output logic                             outWrEnable,
   output logic                             loadUseHazard,
   output logic [$clog2(STAGES+1)-1:0]      occupancy
);

   localparam int CW = $clog2(STAGES+1);

   // Stage state. Only the youngest stage's load flag can ever matter (it is
   // what the entry-side hazard check looks at), so only that one is stored.
   logic [STAGES-1:0]         r_valid;
   logic [STAGES-1:0]         r_wr_en;
   logic                      r_is_load0;
   logic [DATA_WIDTH-1:0]     r_data   [STAGES];
   logic [REG_NUM_WIDTH-1:0]  r_wr_num [STAGES];
   logic [CW-1:0]             r_occ;

   // Per-stage control and the value each stage would load from its source.
   logic [STAGES-1:0]         w_hold;
   logic [STAGES-1:0]         w_kill;
   logic [STAGES-1:0]         w_src_valid;
   logic [STAGES-1:0]         w_src_wr_en;
   logic [STAGES-1:0]         w_valid_next;
   logic [DATA_WIDTH-1:0]     w_src_data   [STAGES];
   logic [REG_NUM_WIDTH-1:0]  w_src_wr_num [STAGES];
   logic [CW-1:0]             w_occ_next;
   logic                      w_hazard;
   logic                      w_ready;
   logic                      w_accept;

   // Entry-side RAW-on-load: the load in stage 0 has no result yet.
   assign w_hazard = inValid && r_valid[0] && r_is_load0 && r_wr_en[0] &&
                     (r_wr_num[0] != '0) &&
                     ((inRdUseA && (inRdNumA == r_wr_num[0])) ||
                      (inRdUseB && (inRdNumB == r_wr_num[0])));

   assign w_ready  = !rst && !w_hold[0] && !flushValid && !w_hazard;
   assign w_accept = inValid && w_ready;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         // A stall anywhere older freezes this stage too.
         assign w_hold[gi] = |stageStall[STAGES-1:gi];
         assign w_kill[gi] = flushValid && (flushStage > CW'(gi));

         if (gi == 0) begin : g_entry
            assign w_src_valid[gi]  = w_accept;
            assign w_src_wr_en[gi]  = w_accept && inWrEnable;
            assign w_src_data[gi]   = inData;
            assign w_src_wr_num[gi] = inWrNum;
         end else begin : g_chain
            // A held or killed predecessor hands over a bubble.
            assign w_src_valid[gi]  = r_valid[gi-1] && !w_hold[gi-1] && !w_kill[gi-1];
            assign w_src_wr_en[gi]  = w_src_valid[gi] && r_wr_en[gi-1];
            assign w_src_data[gi]   = r_data[gi-1];
            assign w_src_wr_num[gi] = r_wr_num[gi-1];
         end

         // Flush beats stall, stall beats advance.
         assign w_valid_next[gi] = w_kill[gi] ? 1'b0 :
                                   w_hold[gi] ? r_valid[gi] : w_src_valid[gi];

         assign stageData[gi*DATA_WIDTH +: DATA_WIDTH] = r_data[gi];
      end
   endgenerate

   // Population count of the next valid vector keeps occupancy exact.
   always_comb begin
      w_occ_next = '0;
      for (int k = 0; k < STAGES; k++) begin
         w_occ_next = w_occ_next + CW'(w_valid_next[k]);
      end
   end

   // Stage registers and occupancy counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid    <= '0;
         r_wr_en    <= '0;
         r_is_load0 <= 1'b0;
         r_occ      <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_data[k]   <= '0;
            r_wr_num[k] <= '0;
         end
      end else begin
         r_valid <= w_valid_next;
         r_occ   <= w_occ_next;
         for (int k = 0; k < STAGES; k++) begin
            if (w_kill[k]) begin
               r_wr_en[k] <= 1'b0;
            end else if (!w_hold[k]) begin
               r_wr_en[k]  <= w_src_wr_en[k];
               r_data[k]   <= w_src_data[k];
               r_wr_num[k] <= w_src_wr_num[k];
            end
         end
         if (w_kill[0]) begin
            r_is_load0 <= 1'b0;
         end else if (!w_hold[0]) begin
            r_is_load0 <= w_accept && inIsLoad;
         end
      end
   end

   assign inReady       = w_ready;
   assign loadUseHazard = w_hazard;
   assign stageValid    = r_valid;
   assign occupancy     = r_occ;
   assign outValid      = r_valid[STAGES-1];
   assign outData       = r_data[STAGES-1];
   assign outWrNum      = r_wr_num[STAGES-1];
   assign outWrEnable   = r_wr_en[STAGES-1];

endmodule

// File: tb/tb_pipeline_stage_chain.sv
// Self-checking bench for pipeline_stage_chain: accepted payloads are queued
// on entry and compared in order as they retire from the oldest stage.
module tb_pipeline_stage_chain;
   localparam int DW = 32;
   localparam int ST = 4;
   localparam int RW = 5;
   localparam int CW = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              inValid;
   logic [DW-1:0]     inData;
   logic [RW-1:0]     inWrNum;
   logic              inWrEnable;
   logic              inIsLoad;
   logic [RW-1:0]     inRdNumA;
   logic [RW-1:0]     inRdNumB;
   logic              inRdUseA;
   logic              inRdUseB;
   logic              inReady;
   logic [ST-1:0]     stageStall;
   logic              flushValid;
   logic [CW-1:0]     flushStage;
   logic [ST-1:0]     stageValid;
   logic [ST*DW-1:0]  stageData;
   logic              outValid;
   logic [DW-1:0]     outData;
   logic [RW-1:0]     outWrNum;
   logic              outWrEnable;
   logic              loadUseHazard;
   logic [CW-1:0]     occupancy;

   int n_err = 0;
   int n_chk = 0;
   logic [DW-1:0] sb_q[$];

   pipeline_stage_chain #(.DATA_WIDTH(DW), .STAGES(ST), .REG_NUM_WIDTH(RW)) dut (
      .clk(clk), .rst(rst), .inValid(inValid), .inData(inData), .inWrNum(inWrNum),
      .inWrEnable(inWrEnable), .inIsLoad(inIsLoad), .inRdNumA(inRdNumA),
      .inRdNumB(inRdNumB), .inRdUseA(inRdUseA), .inRdUseB(inRdUseB),
      .inReady(inReady), .stageStall(stageStall), .flushValid(flushValid),
      .flushStage(flushStage), .stageValid(stageValid), .stageData(stageData),
      .outValid(outValid), .outData(outData), .outWrNum(outWrNum),
      .outWrEnable(outWrEnable), .loadUseHazard(loadUseHazard), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] sd(input int i);
      return stageData[i*DW +: DW];
   endfunction

   task automatic idle;
      inValid = 0; inData = '0; inWrNum = '0; inWrEnable = 0; inIsLoad = 0;
      inRdNumA = '0; inRdNumB = '0; inRdUseA = 0; inRdUseB = 0;
      stageStall = '0; flushValid = 0; flushStage = '0;
   endtask

   task automatic drive(input logic [DW-1:0] d, input logic [RW-1:0] wn,
                        input logic we, input logic ld);
      inValid = 1; inData = d; inWrNum = wn; inWrEnable = we; inIsLoad = ld;
   endtask

   // One clock: record accept/retire just before the edge, settle after it.
   task automatic tick;
      logic acc, ret, was_rst;
      logic [DW-1:0] din, dout, e;
      #1;
      was_rst = rst;
      acc  = inValid && inReady;
      ret  = !rst && outValid && !stageStall[ST-1] && !(flushValid && flushStage == CW'(ST));
      din  = inData;
      dout = outData;
      @(posedge clk);
      #1;
      if (was_rst) begin
         sb_q.delete();
      end else begin
         if (ret) begin
            if (sb_q.size() == 0) begin
               check_eq("sb_underflow", 64'(dout), 64'hdead);
            end else begin
               e = sb_q.pop_front();
               check_eq("sb_retire", 64'(dout), 64'(e));
               $display("retire data=%0h expected=%0h", dout, e);
            end
         end
         if (acc) sb_q.push_back(din);
      end
      check_eq("occ_inv", 64'(occupancy), 64'($countones(stageValid)));
   endtask

   task automatic fill(input logic [DW-1:0] base, input int n);
      for (int k = 0; k < n; k++) begin
         drive(base + DW'(k), 5'd1, 1'b1, 1'b0);
         tick();
      end
      idle();
   endtask

   initial begin
      idle();
      // Reset with entry presented.
      rst = 1; inValid = 1; inData = 32'h99;
      #1 check_eq("rst_ready", 64'(inReady), 0);
      tick(); tick();
      check_eq("rst_valid", 64'(stageValid), 0);
      check_eq("rst_occ", 64'(occupancy), 0);
      check_eq("rst_ready2", 64'(inReady), 0);
      rst = 0;

      // Back-to-back stream 1..6.
      for (int k = 1; k <= 6; k++) begin
         drive(DW'(k), 5'd3, 1'b1, 1'b0);
         tick();
         if (k < 4) check_eq("lat_empty", 64'(outValid), 0);
         else       check_eq("stream_out", 64'(outData), 64'(k - 3));
         if (k == 4) begin
            check_eq("first_valid", 64'(outValid), 1);
            check_eq("occ_peak", 64'(occupancy), 4);
            check_eq("out_wren", 64'(outWrEnable), 1);
            check_eq("out_wrnum", 64'(outWrNum), 3);
         end
      end
      idle();
      repeat (4) tick();
      check_eq("drain_occ", 64'(occupancy), 0);

      // Stall of stage 2 on a full pipe.
      fill(32'hA, 4);
      check_eq("full_s0", 64'(sd(0)), 64'hD);
      check_eq("full_s3", 64'(sd(3)), 64'hA);
      drive(32'hE, 5'd1, 1'b1, 1'b0);
      stageStall = 4'b0100;
      #1 check_eq("stall_ready", 64'(inReady), 0);
      tick();
      check_eq("stall_valid", 64'(stageValid), 64'b0111);
      check_eq("stall_occ", 64'(occupancy), 3);
      check_eq("stall_s2", 64'(sd(2)), 64'hB);
      tick();
      check_eq("stall_hold_s0", 64'(sd(0)), 64'hD);
      check_eq("stall_occ2", 64'(occupancy), 3);
      idle();
      tick();
      check_eq("release_out", 64'(outData), 64'hB);
      check_eq("release_ov", 64'(outValid), 1);
      repeat (3) tick();
      check_eq("stall_drain", 64'(occupancy), 0);

      // Flush of stages 0..1 with a new entry presented.
      fill(32'h11, 4);
      drive(32'h15, 5'd1, 1'b1, 1'b0);
      flushValid = 1; flushStage = 3'd2;
      #1 check_eq("flush_ready", 64'(inReady), 0);
      tick();
      void'(sb_q.pop_back());
      void'(sb_q.pop_back());
      check_eq("flush_valid", 64'(stageValid), 64'b1000);
      check_eq("flush_out", 64'(outData), 64'h12);
      check_eq("flush_occ", 64'(occupancy), 1);
      idle();
      tick();
      check_eq("flush_drain", 64'(occupancy), 0);

      // Load-use hazard.
      drive(32'h21, 5'd5, 1'b1, 1'b1);
      tick();
      drive(32'h22, 5'd6, 1'b1, 1'b0);
      inRdNumA = 5'd5; inRdUseA = 1;
      #1 check_eq("lu_haz", 64'(loadUseHazard), 1);
      check_eq("lu_ready", 64'(inReady), 0);
      inRdUseA = 0;
      #1 check_eq("lu_nouse", 64'(loadUseHazard), 0);
      inRdUseB = 1; inRdNumB = 5'd5;
      #1 check_eq("lu_hazB", 64'(loadUseHazard), 1);
      inRdNumB = 5'd4;
      #1 check_eq("lu_otherB", 64'(loadUseHazard), 0);
      inRdUseB = 0; inRdUseA = 1;
      tick();
      check_eq("lu_bubble", 64'(stageValid[0]), 0);
      check_eq("lu_s1v", 64'(stageValid[1]), 1);
      check_eq("lu_s1d", 64'(sd(1)), 64'h21);
      check_eq("lu_ready2", 64'(inReady), 1);
      tick();
      check_eq("lu_accept", 64'(sd(0)), 64'h22);
      check_eq("lu_acc_v", 64'(stageValid[0]), 1);
      idle();
      // A load to r0 never creates a hazard.
      drive(32'h23, 5'd0, 1'b1, 1'b1);
      tick();
      drive(32'h24, 5'd1, 1'b1, 1'b0);
      inRdNumA = 5'd0; inRdUseA = 1;
      #1 check_eq("lu_r0", 64'(loadUseHazard), 0);
      check_eq("lu_r0_ready", 64'(inReady), 1);
      tick();
      idle();
      repeat (5) tick();
      check_eq("lu_drain", 64'(occupancy), 0);

      // Flush of everything overrides an oldest-stage stall.
      fill(32'h31, 4);
      stageStall = 4'b1000; flushValid = 1; flushStage = 3'd4;
      tick();
      sb_q.delete();
      check_eq("fs_valid", 64'(stageValid), 0);
      check_eq("fs_occ", 64'(occupancy), 0);
      idle();

      // Reset mid-stream with a stall pending.
      fill(32'h41, 3);
      check_eq("mid_occ", 64'(occupancy), 3);
      rst = 1; stageStall = 4'b0001; inValid = 1;
      #1 check_eq("mid_ready", 64'(inReady), 0);
      tick();
      rst = 0;
      idle();
      check_eq("mid_valid", 64'(stageValid), 0);
      check_eq("mid_occ0", 64'(occupancy), 0);
      drive(32'h51, 5'd2, 1'b1, 1'b0);
      tick();
      idle();
      for (int k = 2; k <= 4; k++) begin
         if (k < 4) check_eq("mid_lat", 64'(outValid), 0);
         tick();
      end
      check_eq("mid_out_v", 64'(outValid), 1);
      check_eq("mid_out_d", 64'(outData), 64'h51);
      tick();
      check_eq("sb_empty", 64'(sb_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
